// File: rtl/syn_global_pkg.sv
// Shared CSR offsets, read-default value and decode types for the LB register banks.
package syn_global_pkg;

  localparam int P_CSR_STATUS_OFF   = 'h00;
  localparam int P_CSR_IRQ_MASK_OFF = 'h01;
  localparam int P_CSR_CTRL_OFF     = 'h08;
  localparam int P_CSR_CNTR_OFF     = 'h10;

  localparam logic [31:0] P_CSR_RD_DFLT = 32'hdeadbabe;
  localparam int          P_CSR_CNTR_W  = 16;

  typedef enum logic [2:0] {
    CSR_SEL_NONE,
    CSR_SEL_STATUS,
    CSR_SEL_MASK,
    CSR_SEL_CTRL,
    CSR_SEL_CNTR
  } csr_sel_e;

endpackage

// File: rtl/syn_lb_csr_bank_if.sv
// Local-bus transaction bundle: strobes, address and data toward the bank, acks and read data back.
interface syn_lb_csr_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en, rd_en, addr, wr_data,
    input  wr_valid, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, rd_en, addr, wr_data,
    output wr_valid, rd_valid, rd_data
  );

endinterface

// File: rtl/syn_sat_cntr.sv
// Saturating up-counter; a clear coinciding with an increment restarts the count at 1.
module syn_sat_cntr #(
  parameter int W = 16
) (
  input  logic         clk_ir,
  input  logic         rst_ir,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/syn_lb_csr_bank.sv
// LB control/status register bank: control regs, sticky status, irq mask and registered irq.
// Optional per-status-bit event counters are built when SYN_LB_CSR_EVNT_CNTR_EN is defined.
module syn_lb_csr_bank
  import syn_global_pkg::*;
#(
  parameter int                 DATA_W       = 32,
  parameter int                 ADDR_W       = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = 8'h00,
  parameter int                 NUM_CTRL     = 1,
  parameter int                 NUM_STS      = 2,
  parameter logic [DATA_W-1:0]  CTRL_RST_VAL = '0
) (
  input  logic                         clk_ir,
  input  logic                         rst_ir,
  syn_lb_csr_bank_if.slave             lb,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_regs,
  input  logic [NUM_STS-1:0]           sts_evnt,
  output logic                         irq
);

  logic [ADDR_W-1:0]  off;
  logic               borrow;
  logic               in_blk;
  csr_sel_e           dec_sel;
  logic [3:0]         dec_idx;

  logic [NUM_STS-1:0] sticky_q;
  logic [NUM_STS-1:0] sticky_nxt;
  logic [NUM_STS-1:0] sts_clr;
  logic [NUM_STS-1:0] mask_q;
  logic [NUM_STS-1:0] mask_nxt;
  logic [DATA_W-1:0]  ctrl_q [NUM_CTRL];
  logic [DATA_W-1:0]  rd_mux;

  // The borrow of the offset subtraction marks addresses below the block base.
  assign {borrow, off} = {1'b0, lb.addr} - {1'b0, BASE_ADDR};
  assign in_blk        = ~borrow;

  always_comb begin
    dec_sel = CSR_SEL_NONE;
    dec_idx = '0;
    if (in_blk) begin
      if (off == ADDR_W'(P_CSR_STATUS_OFF)) begin
        dec_sel = CSR_SEL_STATUS;
      end else if (off == ADDR_W'(P_CSR_IRQ_MASK_OFF)) begin
        dec_sel = CSR_SEL_MASK;
      end
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (off == ADDR_W'(P_CSR_CTRL_OFF + i)) begin
          dec_sel = CSR_SEL_CTRL;
          dec_idx = 4'(i);
        end
      end
`ifdef SYN_LB_CSR_EVNT_CNTR_EN
      for (int i = 0; i < NUM_STS; i++) begin
        if (off == ADDR_W'(P_CSR_CNTR_OFF + i)) begin
          dec_sel = CSR_SEL_CNTR;
          dec_idx = 4'(i);
        end
      end
`endif
    end
  end

`ifdef SYN_LB_CSR_EVNT_CNTR_EN
  logic [P_CSR_CNTR_W-1:0] cnt_val [NUM_STS];

  for (genvar g = 0; g < NUM_STS; g++) begin : g_cntr
    syn_sat_cntr #(.W(P_CSR_CNTR_W)) u_cntr (
      .clk_ir (clk_ir),
      .rst_ir (rst_ir),
      .clr    (lb.rd_en && (dec_sel == CSR_SEL_CNTR) && (dec_idx == 4'(g))),
      .inc    (sts_evnt[g]),
      .cnt    (cnt_val[g])
    );
  end
`endif

  // Read mux sees pre-write register values, so a same-cycle read+write returns old data.
  always_comb begin
    rd_mux = DATA_W'(P_CSR_RD_DFLT);
    case (dec_sel)
      CSR_SEL_STATUS: begin
        rd_mux                = '0;
        rd_mux[NUM_STS-1:0]   = sticky_q;
      end
      CSR_SEL_MASK: begin
        rd_mux                = '0;
        rd_mux[NUM_STS-1:0]   = mask_q;
      end
      CSR_SEL_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (dec_idx == 4'(i)) rd_mux = ctrl_q[i];
        end
      end
`ifdef SYN_LB_CSR_EVNT_CNTR_EN
      CSR_SEL_CNTR: begin
        for (int i = 0; i < NUM_STS; i++) begin
          if (dec_idx == 4'(i)) rd_mux = DATA_W'(cnt_val[i]);
        end
      end
`endif
      default: ;
    endcase
  end

  // Events OR in after the clear so an event coinciding with a clear is kept.
  always_comb begin
    sts_clr = '0;
    if (dec_sel == CSR_SEL_STATUS) begin
      if (lb.rd_en) sts_clr = '1;
      if (lb.wr_en) sts_clr = sts_clr | lb.wr_data[NUM_STS-1:0];
    end
    sticky_nxt = (sticky_q & ~sts_clr) | sts_evnt;
    mask_nxt   = (lb.wr_en && (dec_sel == CSR_SEL_MASK)) ? lb.wr_data[NUM_STS-1:0] : mask_q;
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      sticky_q    <= '0;
      mask_q      <= '0;
      irq         <= 1'b0;
      lb.rd_valid <= 1'b0;
      lb.wr_valid <= 1'b0;
      lb.rd_data  <= '0;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_RST_VAL;
    end else begin
      sticky_q    <= sticky_nxt;
      mask_q      <= mask_nxt;
      irq         <= |(sticky_nxt & mask_nxt);
      lb.rd_valid <= lb.rd_en;
      lb.wr_valid <= lb.wr_en;
      if (lb.rd_en) lb.rd_data <= rd_mux;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (lb.wr_en && (dec_sel == CSR_SEL_CTRL) && (dec_idx == 4'(i))) ctrl_q[i] <= lb.wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign ctrl_regs[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

endmodule

// File: tb/tb_syn_lb_csr_bank.sv
// Directed bench for syn_lb_csr_bank: decode, sticky status, irq, reset and optional counters.
module tb_syn_lb_csr_bank;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 8;
  localparam logic [7:0]  B      = 8'h40;
  localparam logic [31:0] RST    = 32'ha5a5_0001;
  localparam logic [31:0] DEAD   = 32'hdeadbabe;

  logic        clk_ir;
  logic        rst_ir;
  logic [63:0] ctrl_regs;
  logic [1:0]  sts_evnt;
  logic        irq;
  int          n_chk;
  int          n_fail;

  syn_lb_csr_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lb_bus ();

  syn_lb_csr_bank #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .BASE_ADDR    (B),
    .NUM_CTRL     (2),
    .NUM_STS      (2),
    .CTRL_RST_VAL (RST)
  ) dut (
    .clk_ir    (clk_ir),
    .rst_ir    (rst_ir),
    .lb        (lb_bus),
    .ctrl_regs (ctrl_regs),
    .sts_evnt  (sts_evnt),
    .irq       (irq)
  );

  initial begin
    clk_ir = 1'b0;
    forever #5 clk_ir = ~clk_ir;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string tag);
    lb_bus.rd_en = 1'b1;
    lb_bus.addr  = a;
    tick();
    lb_bus.rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(lb_bus.rd_valid), 32'd1);
    chk(tag, lb_bus.rd_data, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    lb_bus.wr_en   = 1'b1;
    lb_bus.addr    = a;
    lb_bus.wr_data = d;
    tick();
    lb_bus.wr_en = 1'b0;
    chk("wr_vld", 32'(lb_bus.wr_valid), 32'd1);
  endtask

  task automatic pulse(input logic [1:0] e);
    sts_evnt = e;
    tick();
    sts_evnt = 2'b00;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst_ir         = 1'b1;
    sts_evnt       = 2'b00;
    lb_bus.wr_en   = 1'b0;
    lb_bus.rd_en   = 1'b0;
    lb_bus.addr    = '0;
    lb_bus.wr_data = '0;
    #12;
    chk("rst_rd_data", lb_bus.rd_data, 32'd0);
    chk("rst_rd_vld", 32'(lb_bus.rd_valid), 32'd0);
    chk("rst_wr_vld", 32'(lb_bus.wr_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ctrl0", ctrl_regs[31:0], RST);
    chk("rst_ctrl1", ctrl_regs[63:32], RST);
    rst_ir = 1'b0;
    tick();

    // reset-state reads, valid pulse width, read-data hold
    rd_chk(B + 8'h00, 32'd0, "rd_sts0");
    tick();
    chk("rd_vld_pulse", 32'(lb_bus.rd_valid), 32'd0);
    rd_chk(B + 8'h01, 32'd0, "rd_mask0");
    rd_chk(B + 8'h08, RST, "rd_ctrl0_rst");
    tick();
    chk("rd_vld_pulse2", 32'(lb_bus.rd_valid), 32'd0);
    chk("rd_hold", lb_bus.rd_data, RST);
    chk("irq_idle", 32'(irq), 32'd0);

    // control registers and decode boundaries
    wr(B + 8'h08, 32'h1234_5678);
    chk("ctrl0_wr", ctrl_regs[31:0], 32'h1234_5678);
    chk("ctrl1_keep", ctrl_regs[63:32], RST);
    rd_chk(B + 8'h09, RST, "rd_ctrl1");
    rd_chk(B + 8'h0f, DEAD, "rd_unmap_0f");
    rd_chk(B + 8'h0a, DEAD, "rd_unmap_0a");
`ifdef SYN_LB_CSR_EVNT_CNTR_EN
    rd_chk(B + 8'h10, 32'd0, "rd_cntr0_init");
`else
    rd_chk(B + 8'h10, DEAD, "rd_cntr_absent");
`endif
    rd_chk(8'h08, DEAD, "rd_out_blk");
    wr(B + 8'h1f, 32'hffff_ffff);
    wr(8'h08, 32'h0bad_0bad);
    chk("ctrl0_unmap_wr", ctrl_regs[31:0], 32'h1234_5678);
    chk("ctrl1_unmap_wr", ctrl_regs[63:32], RST);

    // simultaneous read and write of the same register
    lb_bus.rd_en   = 1'b1;
    lb_bus.wr_en   = 1'b1;
    lb_bus.addr    = B + 8'h08;
    lb_bus.wr_data = 32'hcafe_f00d;
    tick();
    lb_bus.rd_en = 1'b0;
    lb_bus.wr_en = 1'b0;
    chk("rw_rd_old", lb_bus.rd_data, 32'h1234_5678);
    chk("rw_rd_vld", 32'(lb_bus.rd_valid), 32'd1);
    chk("rw_wr_vld", 32'(lb_bus.wr_valid), 32'd1);
    chk("rw_ctrl_new", ctrl_regs[31:0], 32'hcafe_f00d);

    // sticky status, mask and irq
    pulse(2'b01);
    chk("irq_masked", 32'(irq), 32'd0);
    wr(B + 8'h01, 32'h0000_0001);
    chk("irq_unmask", 32'(irq), 32'd1);
    rd_chk(B + 8'h01, 32'd1, "rd_mask1");
    rd_chk(B + 8'h00, 32'd1, "rd_sts_set");
    chk("irq_clr_rd", 32'(irq), 32'd0);
    tick();
    chk("irq_after_vld", 32'(irq), 32'd0);
    rd_chk(B + 8'h00, 32'd0, "rd_sts_cleared");

    // read of STATUS coinciding with a new event
    pulse(2'b01);
    chk("irq_reset_evt", 32'(irq), 32'd1);
    sts_evnt     = 2'b10;
    lb_bus.rd_en = 1'b1;
    lb_bus.addr  = B + 8'h00;
    tick();
    sts_evnt     = 2'b00;
    lb_bus.rd_en = 1'b0;
    chk("rd_sts_old", lb_bus.rd_data, 32'd1);
    chk("irq_bit1_masked", 32'(irq), 32'd0);
    rd_chk(B + 8'h00, 32'd2, "rd_sts_kept_evt");

    // write-1-to-clear
    pulse(2'b11);
    wr(B + 8'h00, 32'h0000_0002);
    chk("irq_w1c_keep", 32'(irq), 32'd1);
    rd_chk(B + 8'h00, 32'd1, "rd_sts_w1c");
    chk("irq_w1c_rd", 32'(irq), 32'd0);

`ifdef SYN_LB_CSR_EVNT_CNTR_EN
    // bit1 saw one event in each of the last two sections
    rd_chk(B + 8'h11, 32'd2, "rd_cntr1");
    sts_evnt = 2'b01;
    repeat (70000) tick();
    sts_evnt = 2'b00;
    rd_chk(B + 8'h10, 32'h0000_ffff, "cntr_sat");
    rd_chk(B + 8'h10, 32'd0, "cntr_rd_clr");
    sts_evnt = 2'b01;
    repeat (3) tick();
    lb_bus.rd_en = 1'b1;
    lb_bus.addr  = B + 8'h10;
    tick();
    lb_bus.rd_en = 1'b0;
    sts_evnt     = 2'b00;
    chk("cntr_rd_evt", lb_bus.rd_data, 32'd3);
    rd_chk(B + 8'h10, 32'd1, "cntr_after_rd_evt");
`endif

    // asynchronous reset mid-transaction
    pulse(2'b01);
    chk("irq_pre_rst", 32'(irq), 32'd1);
    lb_bus.rd_en = 1'b1;
    lb_bus.addr  = B + 8'h08;
    tick();
    chk("pre_rst_vld", 32'(lb_bus.rd_valid), 32'd1);
    rst_ir = 1'b1;
    #1;
    chk("arst_rd_vld", 32'(lb_bus.rd_valid), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_ctrl0", ctrl_regs[31:0], RST);
    chk("arst_rd_data", lb_bus.rd_data, 32'd0);
    @(posedge clk_ir);
    #1;
    chk("rst_drop_vld", 32'(lb_bus.rd_valid), 32'd0);
    lb_bus.rd_en = 1'b0;
    rst_ir       = 1'b0;
    tick();
    rd_chk(B + 8'h01, 32'd0, "post_rst_mask");
    rd_chk(B + 8'h00, 32'd0, "post_rst_sts");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_lb_csr_bank.md
# syn_lb_csr_bank

Parametrised local-bus control/status register bank, the generalised successor to the per-block VGA LB decoders. Decodes LB read/write transactions against a base address and provides N control registers, M sticky (clear-on-read / write-1-to-clear) status bits, an interrupt mask and a registered interrupt output. It is instantiated inside each visual-cortex/acortex sub-block, between the shared LB fabric and the block's local control and status signals.

## Interface
- `DATA_W`, 32: LB data width; must be at least `NUM_STS`.
- `ADDR_W`, 8: LB address width.
- `BASE_ADDR`, 8'h00: block base address; offsets below are added to it.
- `NUM_CTRL`, 1: number of control registers, 1..8.
- `NUM_STS`, 2: number of sticky status bits, 1..16.
- `CTRL_RST_VAL`, 0: reset value of every control register.
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- `clk_ir`  in  1  block clock.
- `rst_ir`  in  1  asynchronous, active-high reset.
- `lb_wr_en`  in  1  write strobe, one cycle per transaction.
- `lb_rd_en`  in  1  read strobe, one cycle per transaction.
- `lb_addr`  in  ADDR_W  transaction address.
- `lb_wr_data`  in  DATA_W  write data.
- `lb_wr_valid`  out  1  write acknowledge.
- `lb_rd_valid`  out  1  read data valid.
- `lb_rd_data`  out  DATA_W  read data.
- `ctrl_regs`  out  NUM_CTRL*DATA_W  flattened control registers; register i occupies bits [i*DATA_W +: DATA_W].
- `sts_evnt`  in  NUM_STS  per-bit event pulses; a bit that is high in a cycle counts as one event.
- `irq`  out  1  registered interrupt.

## Operation
- Offset map:
  - 0x00 STATUS: sticky bits in [NUM_STS-1:0]; read clears; writing 1 to a bit clears it.
  - 0x01 IRQ_MASK: R/W, bits [NUM_STS-1:0]; reset value 0.
  - 0x08+i CTRL[i]: R/W.
  - 0x10+i EVNT_CNT[i]: present only under the macro in Configuration.
- Unused bits read as 0. A read of an unmapped offset, or of an address outside the block, returns 32'hdeadbabe. Writes to unmapped offsets are ignored, but `lb_wr_valid` still pulses.
- Sticky bit j:
  - next = (sticky_j & ~clr_j) | sts_evnt[j].
  - clr_j = (read of STATUS) | (write of STATUS with wr_data[j]=1).
  - An event and a clear in the same cycle leaves the bit set, so no event is lost.
- `irq` next = |(next_sticky & mask).
- `lb_rd_en` and `lb_wr_en` in the same cycle are both executed. The read returns the pre-write value.
- Reset state: every output is 0, except `ctrl_regs`, which holds CTRL_RST_VAL. All sticky bits, mask bits and counters are 0. `lb_rd_data` is 0.

## Timing
- Write at cycle N: register updated and `lb_wr_valid`=1 at N+1.
- Read at cycle N: `lb_rd_data` and `lb_rd_valid`=1 at N+1. A clear-on-read takes effect at N+1.
- `lb_rd_data` holds its value between reads; `lb_rd_valid` is a single-cycle pulse.
- `sts_evnt` high at N: STATUS bit visible to a read issued at N+1; `irq` high at N+1.
- Mask written at N: `irq` reflects the new mask at N+1.
- Back-to-back transactions every cycle are supported with no stall.
- Reset asserted mid-transaction: the pending `lb_rd_valid`/`lb_wr_valid` is dropped. All state returns to reset values asynchronously.

## Configuration
- `SYN_LB_CSR_EVNT_CNTR_EN` defined:
  - One 16-bit saturating counter per status bit, at offsets 0x10+i, read in bits [15:0].
  - Each counter increments on every cycle its `sts_evnt` bit is high and holds at 16'hFFFF.
  - Read clears the counter. A read and an event in the same cycle leave the counter at 1.
- Macro undefined: no counters are built, and offsets 0x10+ read 32'hdeadbabe.

## Structure
- `syn_global_pkg` holds:
  - offset localparams `P_CSR_STATUS_OFF`, `P_CSR_IRQ_MASK_OFF`, `P_CSR_CTRL_OFF`, `P_CSR_CNTR_OFF`;
  - `P_CSR_RD_DFLT` = 32'hdeadbabe;
  - `P_CSR_CNTR_W` = 16.
- One sub-module, `syn_sat_cntr`: a parametrised-width saturating counter with clear and increment inputs, instantiated once per status bit under the macro.

## Test plan
- Reset, then read 0x00, 0x01 and 0x08: returns 0, 0 and CTRL_RST_VAL. `irq`=0; rd_valid pulses exactly one cycle after each rd_en.
- Write 0x08 = 32'h1234_5678 with NUM_CTRL=2: `ctrl_regs[31:0]` updates on the next cycle. Read 0x09 returns CTRL_RST_VAL. Read 0x0F returns 32'hdeadbabe.
- Pulse `sts_evnt`=2'b01, write IRQ_MASK=1: `irq` goes to 1. Read STATUS returns 1; `irq` is 0 the cycle after rd_valid. A second read returns 0.
- Read STATUS in the same cycle as `sts_evnt[1]` pulses: the read returns the old value, and the following read returns 2'b10.
- Write STATUS = 2'b10 with both bits set: the next read returns 2'b01.
- With the macro defined, hold `sts_evnt[0]` high for 70000 cycles: EVNT_CNT[0] reads 16'hFFFF. A read that coincides with an event leaves the next read at 1.
